// File: rtl/delay_tester_pkg.sv
// Shared definitions for the delay tester: frame geometry, field offsets and
// the test-frame byte map used by both the transmit generator and the checker.
package delay_tester_pkg;

  localparam int unsigned ETH_MIN_LEN = 60;
  localparam int unsigned ETH_MAX_LEN = 1514;
  localparam int unsigned LEN_W       = 11;
  localparam int unsigned WIDX_W      = 9;

  localparam int unsigned DST_OFS  = 0;
  localparam int unsigned SRC_OFS  = 6;
  localparam int unsigned TYPE_OFS = 12;
  localparam int unsigned SEQ_OFS  = 14;
  localparam int unsigned TS_OFS   = 18;
  localparam int unsigned PAD_OFS  = 26;

  localparam logic [15:0] ETH_TYPE_DEFAULT = 16'h88B5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    logic [31:0] seq;
    logic [63:0] ts;
  } frame_hdr_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (32'(len) < ETH_MIN_LEN) return LEN_W'(ETH_MIN_LEN);
    if (32'(len) > ETH_MAX_LEN) return LEN_W'(ETH_MAX_LEN);
    return len;
  endfunction

  function automatic logic [WIDX_W-1:0] word_count(input logic [LEN_W-1:0] len);
    return WIDX_W'((32'(len) + 32'd3) >> 2);
  endfunction

  // Unused byte lanes in the last word of a len-byte frame.
  function automatic logic [1:0] eop_empty(input logic [LEN_W-1:0] len);
    return 2'(3'd4 - {1'b0, len[1:0]});
  endfunction

  // Byte at offset bidx of the frame; zero past the end of the frame.
  function automatic logic [7:0] frame_byte(input frame_hdr_t hdr,
                                            input logic [LEN_W-1:0] len,
                                            input logic [LEN_W-1:0] bidx);
    int unsigned i;
    logic [47:0] mac;
    logic [31:0] sq;
    logic [63:0] ts;
    logic [7:0]  b;
    i   = 32'(bidx);
    mac = '0;
    sq  = '0;
    ts  = '0;
    b   = 8'h00;
    if (bidx >= len) begin
      b = 8'h00;
    end else if (i < SRC_OFS) begin
      mac = hdr.dst << (8 * (i - DST_OFS));
      b   = mac[47:40];
    end else if (i < TYPE_OFS) begin
      mac = hdr.src << (8 * (i - SRC_OFS));
      b   = mac[47:40];
    end else if (i == TYPE_OFS) begin
      b = hdr.etype[15:8];
    end else if (i < SEQ_OFS) begin
      b = hdr.etype[7:0];
    end else if (i < TS_OFS) begin
      sq = hdr.seq << (8 * (i - SEQ_OFS));
      b  = sq[31:24];
    end else if (i < PAD_OFS) begin
      ts = hdr.ts << (8 * (i - TS_OFS));
      b  = ts[63:56];
    end else begin
      b = bidx[7:0];
    end
    return b;
  endfunction

  // Big-endian 32-bit word widx of the frame; first byte on [31:24].
  function automatic logic [31:0] frame_word(input frame_hdr_t hdr,
                                             input logic [LEN_W-1:0] len,
                                             input logic [WIDX_W-1:0] widx);
    logic [LEN_W-1:0] base;
    base = {widx, 2'b00};
    return {frame_byte(hdr, len, base),
            frame_byte(hdr, len, base + LEN_W'(1)),
            frame_byte(hdr, len, base + LEN_W'(2)),
            frame_byte(hdr, len, base + LEN_W'(3))};
  endfunction

endpackage

// File: rtl/eth_delay_tx_gen.sv
// Timestamped test-frame generator feeding the MAC transmit Avalon-ST sink.
// Frames carry a sequence number and the launch-time cycle counter.
module eth_delay_tx_gen
  import delay_tester_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = ETH_TYPE_DEFAULT,
  parameter int unsigned TS_W      = 64
) (
  input  logic        clk_125m_i,
  input  logic        srst_n_i,
  input  logic        en_i,
  input  logic [10:0] frame_len_i,
  input  logic [15:0] gap_i,
  input  logic [47:0] dst_mac_i,
  input  logic [47:0] src_mac_i,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        tx_sop_o,
  output logic        tx_eop_o,
  output logic [1:0]  tx_empty_o,
  output logic        tx_error_o,
  output logic [31:0] seq_o,
  output logic [31:0] frames_sent_o,
  output logic [63:0] ts_o
);

  tx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [WIDX_W-1:0] wcnt_q, wcnt_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [47:0]       dst_q, dst_d;
  logic [47:0]       src_q, src_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [TS_W-1:0]   tslat_q, tslat_d;
  logic [31:0]       seq_q, seq_d;
  logic [31:0]       frames_q, frames_d;
  logic [15:0]       gap_q, gap_d;

  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [1:0]        empty_q, empty_d;

  logic              launch;
  logic              last_word;
  frame_hdr_t        hdr;

  // Next-state logic; a launch latches the frame parameters for its duration.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    widx_d    = widx_q;
    dst_d     = dst_q;
    src_d     = src_q;
    tslat_d   = tslat_q;
    seq_d     = seq_q;
    frames_d  = frames_q;
    gap_d     = gap_q;
    ts_d      = ts_q + TS_W'(1);
    launch    = 1'b0;
    last_word = (widx_q == wcnt_q - WIDX_W'(1));

    case (state_q)
      IDLE: launch = en_i;
      SEND: begin
        if (tx_ready_i) begin
          if (last_word) begin
            seq_d    = seq_q + 32'd1;
            frames_d = frames_q + 32'd1;
            gap_d    = gap_i;
            state_d  = GAP;
          end else begin
            widx_d = widx_q + WIDX_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_q != 16'd0) begin
          gap_d = gap_q - 16'd1;
        end else if (en_i) begin
          launch = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d = SEND;
      len_d   = clamp_len(frame_len_i);
      wcnt_d  = word_count(len_d);
      widx_d  = '0;
      dst_d   = dst_mac_i;
      src_d   = src_mac_i;
      tslat_d = ts_q;
    end
  end

  // Stream outputs for the word to be presented after this edge; stalls hold them.
  always_comb begin
    hdr     = '{dst: dst_d, src: src_d, etype: ETHERTYPE, seq: seq_d, ts: 64'(tslat_d)};
    valid_d = (state_d == SEND);
    sop_d   = valid_d && (widx_d == '0);
    eop_d   = valid_d && (widx_d == wcnt_d - WIDX_W'(1));
    empty_d = eop_d ? eop_empty(len_d) : 2'd0;
    data_d  = valid_d ? frame_word(hdr, len_d, widx_d) : 32'd0;
  end

  always_ff @(posedge clk_125m_i) begin
    if (!srst_n_i) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wcnt_q   <= '0;
      widx_q   <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      ts_q     <= '0;
      tslat_q  <= '0;
      seq_q    <= '0;
      frames_q <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      empty_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wcnt_q   <= wcnt_d;
      widx_q   <= widx_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      ts_q     <= ts_d;
      tslat_q  <= tslat_d;
      seq_q    <= seq_d;
      frames_q <= frames_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      empty_q  <= empty_d;
    end
  end

  assign tx_data_o     = data_q;
  assign tx_valid_o    = valid_q;
  assign tx_sop_o      = sop_q;
  assign tx_eop_o      = eop_q;
  assign tx_empty_o    = empty_q;
  assign tx_error_o    = 1'b0;
  assign seq_o         = seq_q;
  assign frames_sent_o = frames_q;
  assign ts_o          = 64'(ts_q);

endmodule

// File: tb/tb_eth_delay_tx_gen.sv
// Directed bench for eth_delay_tx_gen: frame contents, framing flags, gaps,
// stalls, enable drop and mid-frame reset against a bench-side byte model.
module tb_eth_delay_tx_gen;

  logic        clk_125m_i = 1'b0;
  logic        srst_n_i;
  logic        en_i;
  logic [10:0] frame_len_i;
  logic [15:0] gap_i;
  logic [47:0] dst_mac_i;
  logic [47:0] src_mac_i;
  logic [31:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        tx_sop_o;
  logic        tx_eop_o;
  logic [1:0]  tx_empty_o;
  logic        tx_error_o;
  logic [31:0] seq_o;
  logic [31:0] frames_sent_o;
  logic [63:0] ts_o;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] cyc      = '0;

  eth_delay_tx_gen dut (
    .clk_125m_i    (clk_125m_i),
    .srst_n_i      (srst_n_i),
    .en_i          (en_i),
    .frame_len_i   (frame_len_i),
    .gap_i         (gap_i),
    .dst_mac_i     (dst_mac_i),
    .src_mac_i     (src_mac_i),
    .tx_data_o     (tx_data_o),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i),
    .tx_sop_o      (tx_sop_o),
    .tx_eop_o      (tx_eop_o),
    .tx_empty_o    (tx_empty_o),
    .tx_error_o    (tx_error_o),
    .seq_o         (seq_o),
    .frames_sent_o (frames_sent_o),
    .ts_o          (ts_o)
  );

  always #4 clk_125m_i = ~clk_125m_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the bench cycle counter mirrors the expected timestamp.
  task automatic step();
    @(posedge clk_125m_i);
    if (!srst_n_i) cyc = '0;
    else cyc = cyc + 64'd1;
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [47:0] d, input logic [47:0] s,
                                           input logic [31:0] sq, input logic [63:0] ts,
                                           input int len, input int w);
    logic [7:0] eb [0:3];
    int i;
    for (int k = 0; k < 4; k++) begin
      i = 4 * w + k;
      if (i >= len)      eb[k] = 8'h00;
      else if (i < 6)    eb[k] = d[8*(5-i) +: 8];
      else if (i < 12)   eb[k] = s[8*(11-i) +: 8];
      else if (i == 12)  eb[k] = 8'h88;
      else if (i == 13)  eb[k] = 8'hB5;
      else if (i < 18)   eb[k] = sq[8*(17-i) +: 8];
      else if (i < 26)   eb[k] = ts[8*(25-i) +: 8];
      else               eb[k] = 8'(i);
    end
    return {eb[0], eb[1], eb[2], eb[3]};
  endfunction

  // Wait for a frame start, then check every presented word until eop transfers.
  task automatic get_frame(input int len, input logic [31:0] sq, input bit rnd,
                           input int drop_at, input bit scramble);
    int          n;
    int          nw;
    int          widx;
    logic [63:0] ts_e;
    logic [47:0] d;
    logic [47:0] s;
    logic [1:0]  emp;
    logic        rdy;
    d = dst_mac_i;
    s = src_mac_i;
    n = 0;
    while (!tx_valid_o && n < 3000) begin
      step();
      n++;
    end
    if (!tx_valid_o) begin
      chk("sop_timeout", 64'd0, 64'd1);
      return;
    end
    ts_e = cyc - 64'd1;
    nw   = (len + 3) / 4;
    widx = 0;
    n    = 0;
    while (widx < nw && n < 20000) begin
      emp = (widx == nw - 1) ? 2'(4 * nw - len) : 2'd0;
      chk($sformatf("f%0d_w%0d", sq, widx),
          {27'd0, tx_valid_o, tx_sop_o, tx_eop_o, tx_empty_o, tx_data_o},
          {27'd0, 1'b1, 1'(widx == 0), 1'(widx == nw - 1), emp,
           exp_word(d, s, sq, ts_e, len, widx)});
      if (widx == drop_at) en_i = 1'b0;
      if (scramble && widx == 2) begin
        frame_len_i = 11'd300;
        dst_mac_i   = ~dst_mac_i;
        src_mac_i   = ~src_mac_i;
      end
      rdy        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready_i = rdy;
      step();
      n++;
      if (rdy) widx++;
    end
    tx_ready_i = 1'b1;
    chk("frame_done", 64'(widx), 64'(nw));
    chk("seq_after", 64'(seq_o), 64'(sq + 32'd1));
  endtask

  task automatic gap_count(input int exp);
    int n;
    n = 0;
    while (!tx_valid_o && n < 200) begin
      n++;
      step();
    end
    chk("gap_cycles", 64'(n), 64'(exp));
  endtask

  task automatic expect_idle(input int cycles);
    int v;
    v = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (tx_valid_o) v++;
    end
    chk("idle_no_sop", 64'(v), 64'd0);
  endtask

  initial begin
    int n;
    srst_n_i    = 1'b0;
    en_i        = 1'b0;
    tx_ready_i  = 1'b1;
    frame_len_i = 11'd60;
    gap_i       = 16'd0;
    dst_mac_i   = 48'h0011_2233_4455;
    src_mac_i   = 48'h6677_8899_AABB;
    repeat (3) step();

    chk("rst_valid", 64'(tx_valid_o), 64'd0);
    chk("rst_flags", 64'({tx_sop_o, tx_eop_o, tx_empty_o, tx_error_o}), 64'd0);
    chk("rst_data", 64'(tx_data_o), 64'd0);
    chk("rst_seq", 64'(seq_o), 64'd0);
    chk("rst_frames", 64'(frames_sent_o), 64'd0);
    chk("rst_ts", ts_o, 64'd0);

    srst_n_i = 1'b1;
    repeat (5) step();
    chk("ts_count", ts_o, 64'd5);

    // 60-byte frames back to back with zero gap, then stop
    en_i = 1'b1;
    get_frame(60, 32'd0, 1'b0, -1, 1'b0);
    chk("frames_1", 64'(frames_sent_o), 64'd1);
    gap_count(1);
    get_frame(60, 32'd1, 1'b0, 0, 1'b0);
    chk("frames_2", 64'(frames_sent_o), 64'd2);
    expect_idle(10);

    // 61 bytes; inputs changed mid-frame must not affect it
    frame_len_i = 11'd61;
    en_i = 1'b1;
    get_frame(61, 32'd2, 1'b0, 0, 1'b1);
    expect_idle(5);

    // clamping at both ends
    frame_len_i = 11'd10;
    en_i = 1'b1;
    get_frame(60, 32'd3, 1'b0, 0, 1'b0);
    expect_idle(5);
    frame_len_i = 11'd2000;
    en_i = 1'b1;
    get_frame(1514, 32'd4, 1'b0, 0, 1'b0);
    expect_idle(5);

    // reset in the middle of a frame
    frame_len_i = 11'd60;
    en_i = 1'b1;
    n = 0;
    while (!tx_valid_o && n < 100) begin
      step();
      n++;
    end
    repeat (7) step();
    chk("pre_rst_valid", 64'(tx_valid_o), 64'd1);
    srst_n_i = 1'b0;
    en_i     = 1'b0;
    step();
    chk("mid_rst_valid", 64'(tx_valid_o), 64'd0);
    chk("mid_rst_seq", 64'(seq_o), 64'd0);
    chk("mid_rst_frames", 64'(frames_sent_o), 64'd0);
    chk("mid_rst_ts", ts_o, 64'd0);
    srst_n_i = 1'b1;

    // gap of 5 with random back-pressure, last frame loses enable at word 4
    gap_i = 16'd5;
    en_i  = 1'b1;
    get_frame(60, 32'd0, 1'b1, -1, 1'b0);
    chk("frames_g1", 64'(frames_sent_o), 64'd1);
    gap_count(6);
    get_frame(60, 32'd1, 1'b1, -1, 1'b0);
    chk("frames_g2", 64'(frames_sent_o), 64'd2);
    gap_count(6);
    get_frame(60, 32'd2, 1'b0, 4, 1'b0);
    chk("frames_g3", 64'(frames_sent_o), 64'd3);
    expect_idle(20);
    chk("ts_track", ts_o, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
